hub75_bcm_scan: RTL and testbench
=================================

HUB75_BCM_SCAN -- requirements
Module: hub75_bcm_scan

Interface
REQ-001 SHALL have these parameters:
- COLS, 64, columns shifted per row, at least 2.
- SCAN_ROWS, 32, row addresses per frame, power of two.
- ADDR_W, 5, equal to log2(SCAN_ROWS).
- BPC, 4, bits per colour channel, 1..8.
- CLK_DIV, 2, clk cycles per clk_out phase, at least 1.
- BASE_ON, 32, oe-low cycles for bit-plane 0, at least 1.
- DEAD_CYC, 4, blanking cycles, at least 1, used only with HUB75_DEADTIME_EN.

REQ-002 SHALL have these ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  scan enable, sampled at frame boundary.
- pix_rd  out  1  pixel read strobe.
- pix_row  out  ADDR_W  row of the requested pixel pair.
- pix_col  out  clog2(COLS)  column of the requested pixel.
- pix_data  in  6*BPC  pixel data, valid exactly one cycle after pix_rd. Fields from LSB: r0, g0, b0, r1, g1, b1, each BPC bits.
- r0 g0 b0 r1 g1 b1  out  1 each  panel colour data.
- addr  out  ADDR_W  panel row address.
- clk_out  out  1  panel shift clock.
- latch  out  1  panel latch.
- oe  out  1  panel output enable, active-low.
- frame_start  out  1  one-cycle pulse at the start of each frame.

Function
REQ-003 Frame order SHALL be: for row = 0..SCAN_ROWS-1, for plane = 0..BPC-1: SHIFT, then LATCH, then [BLANK], then DISPLAY.
REQ-004 States SHALL be IDLE, SHIFT, LATCH, BLANK and DISPLAY.
REQ-005 IDLE SHALL hold oe=1 and clk_out=0; it SHALL go to SHIFT with row=0 and plane=0 when en=1, and pulse frame_start on that transition.
REQ-006 SHIFT SHALL fetch each column c=0..COLS-1 in turn: pix_rd=1 for one cycle with pix_row=row and pix_col=c.
REQ-007 In SHIFT, the colour outputs SHALL take bit [plane] of each field in the cycle after pix_rd, while clk_out=0.
REQ-008 Each column SHALL then hold clk_out=0 for CLK_DIV cycles followed by clk_out=1 for CLK_DIV cycles; colour data SHALL be stable for the whole clk_out-high phase.
REQ-009 oe SHALL be 1 throughout SHIFT.
REQ-010 After the high phase of column COLS-1, clk_out SHALL return to 0 and the block SHALL enter LATCH.
REQ-011 LATCH SHALL last exactly one cycle with latch=1, oe=1 and clk_out=0; latch SHALL be 0 in every other state.
REQ-012 In LATCH with plane=0, addr SHALL load row; addr SHALL change at no other time and never while oe=0.
REQ-013 DISPLAY SHALL hold oe=0 for exactly BASE_ON<<plane cycles, computed at ADDR_W+BPC+16-bit width with no overflow, then set oe=1 in the following cycle.
REQ-014 After DISPLAY the block SHALL advance in this order:
- If plane<BPC-1: plane+1, go to SHIFT.
- Else if row<SCAN_ROWS-1: plane=0, row+1, go to SHIFT.
- Else (row wraps to 0): go to SHIFT and pulse frame_start if en=1, otherwise go to IDLE.
REQ-015 en SHALL be ignored except at the frame boundary; deassertion mid-frame SHALL complete the frame first.
REQ-016 pix_data SHALL be ignored in every cycle not immediately following pix_rd.
REQ-017 Exactly one pix_rd SHALL be issued per column per plane, giving COLS*BPC*SCAN_ROWS reads per frame.

Reset
REQ-018 rst=1 SHALL force, on the next clk edge:
- state=IDLE.
- oe=1.
- latch, clk_out, pix_rd, frame_start and all colour outputs = 0.
- addr, row, plane, column and timing counters = 0.
REQ-019 Reset asserted mid-operation SHALL take effect on the next edge from any state, with no partial latch pulse and no oe=0 cycle after it.

Configuration
REQ-020 With HUB75_DEADTIME_EN defined, LATCH SHALL be followed by BLANK, holding oe=1 and clk_out=0 for DEAD_CYC cycles, before DISPLAY.
REQ-021 With HUB75_DEADTIME_EN undefined, BLANK SHALL not exist, LATCH SHALL go directly to DISPLAY, and DEAD_CYC SHALL be unused.

Verification
Bench parameters for all scenarios: COLS=4, SCAN_ROWS=2, ADDR_W=1, BPC=2, CLK_DIV=1, BASE_ON=4.
REQ-022 Reset then en=1 -> frame_start pulses once; 4 clk_out rising edges; one latch pulse; oe low 4 cycles (plane 0); then 4 edges, latch, oe low 8 cycles (plane 1).
REQ-023 pix_data r0 field=2'b10 for every column -> r0=0 on all plane-0 clk_out rising edges and r0=1 on all plane-1 rising edges.
REQ-024 Full frame -> addr goes 0 then 1 then 0 (wrap), each change in a LATCH cycle with oe=1; pix_rd count=16; frame_start pulses again at the wrap.
REQ-025 en dropped during row 0 -> frame completes through row 1 plane 1, then IDLE with oe=1 and no further pix_rd.
REQ-026 rst asserted during DISPLAY -> next cycle oe=1, addr=0, state IDLE; on restart with en=1, a complete frame follows.
REQ-027 HUB75_DEADTIME_EN defined with DEAD_CYC=3 -> exactly 3 cycles with oe=1 between the latch pulse and the first oe=0 cycle; undefined -> oe=0 in the cycle immediately after latch.

Source files
------------

// File: rtl/hub75_bcm_scan.sv
// HUB75 panel scanner: fetches pixel pairs, shifts one bit-plane per pass and
// displays it for BASE_ON<<plane cycles. Optional dead time: HUB75_DEADTIME_EN.
module hub75_bcm_scan #(
  parameter int COLS      = 64,
  parameter int SCAN_ROWS = 32,
  parameter int ADDR_W    = 5,
  parameter int BPC       = 4,
  parameter int CLK_DIV   = 2,
  parameter int BASE_ON   = 32,
  parameter int DEAD_CYC  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  output logic                    pix_rd,
  output logic [ADDR_W-1:0]       pix_row,
  output logic [$clog2(COLS)-1:0] pix_col,
  input  logic [6*BPC-1:0]        pix_data,
  output logic                    r0,
  output logic                    g0,
  output logic                    b0,
  output logic                    r1,
  output logic                    g1,
  output logic                    b1,
  output logic [ADDR_W-1:0]       addr,
  output logic                    clk_out,
  output logic                    latch,
  output logic                    oe,
  output logic                    frame_start
);

  localparam int COL_W = $clog2(COLS);
  localparam int PL_W  = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int OW    = ADDR_W + BPC + 16;

  localparam logic [COL_W-1:0]  COL_ZERO = {COL_W{1'b0}};
  localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
  localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
  localparam logic [ADDR_W-1:0] ROW_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ROW_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(SCAN_ROWS - 1);
  localparam logic [PL_W-1:0]   PL_ZERO  = {PL_W{1'b0}};
  localparam logic [PL_W-1:0]   PL_ONE   = PL_W'(1);
  localparam logic [PL_W-1:0]   PL_LAST  = PL_W'(BPC - 1);
  localparam logic [OW-1:0]     T_ZERO   = {OW{1'b0}};
  localparam logic [OW-1:0]     T_ONE    = OW'(1);
  localparam logic [OW-1:0]     T_CAP    = OW'(1);
  localparam logic [OW-1:0]     T_HIGH   = OW'(CLK_DIV + 2);
  localparam logic [OW-1:0]     T_LAST   = OW'(2 * CLK_DIV + 1);
  localparam logic [OW-1:0]     T_BASE   = OW'(BASE_ON);
`ifdef HUB75_DEADTIME_EN
  localparam logic [OW-1:0]     T_DEAD   = OW'(DEAD_CYC - 1);
`endif

`ifdef HUB75_DEADTIME_EN
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    LATCH   = 3'd2,
    BLANK   = 3'd3,
    DISPLAY = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    LATCH   = 3'd2,
    DISPLAY = 3'd4
  } state_t;
`endif

  state_t            state_r, state_s;
  logic [OW-1:0]     tmr_r, tmr_s;
  logic [COL_W-1:0]  col_r, col_s;
  logic [ADDR_W-1:0] row_r, row_s;
  logic [PL_W-1:0]   plane_r, plane_s;
  logic              fs_s;
  logic [OW-1:0]     disp_last_s;
  logic [5:0]        rgb_r;

  // Bit [pl] of each of the six colour fields, field 0 in bit 0.
  function automatic logic [5:0] plane_bits(input logic [6*BPC-1:0] data,
                                            input logic [PL_W-1:0]  pl);
    logic [5:0] bits;
    bits = 6'd0;
    for (int k = 0; k < 6; k++) begin
      bits[k] = data[k*BPC + int'(pl)];
    end
    return bits;
  endfunction

  assign pix_row = row_r;
  assign pix_col = col_r;
  assign r0 = rgb_r[0];
  assign g0 = rgb_r[1];
  assign b0 = rgb_r[2];
  assign r1 = rgb_r[3];
  assign g1 = rgb_r[4];
  assign b1 = rgb_r[5];

  // Display window for the current plane, minus one as the count-down start.
  always_comb begin
    disp_last_s = (T_BASE << plane_r) - T_ONE;
  end

  // Next-state logic: SHIFT phases are 0 fetch, 1 capture, then low and high halves.
  always_comb begin
    state_s = state_r;
    tmr_s   = tmr_r;
    col_s   = col_r;
    row_s   = row_r;
    plane_s = plane_r;
    fs_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (en) begin
          state_s = SHIFT;
          tmr_s   = T_ZERO;
          col_s   = COL_ZERO;
          row_s   = ROW_ZERO;
          plane_s = PL_ZERO;
          fs_s    = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (tmr_r == T_LAST) begin
          tmr_s = T_ZERO;
          if (col_r == COL_LAST) begin
            state_s = LATCH;
          end else begin
            col_s = col_r + COL_ONE;
          end
        end else begin
          tmr_s = tmr_r + T_ONE;
        end
      end
      LATCH: begin
`ifdef HUB75_DEADTIME_EN
        state_s = BLANK;
        tmr_s   = T_DEAD;
`else
        state_s = DISPLAY;
        tmr_s   = disp_last_s;
`endif
      end
`ifdef HUB75_DEADTIME_EN
      BLANK: begin
        if (tmr_r == T_ZERO) begin
          state_s = DISPLAY;
          tmr_s   = disp_last_s;
        end else begin
          tmr_s = tmr_r - T_ONE;
        end
      end
`endif
      DISPLAY: begin
        if (tmr_r == T_ZERO) begin
          tmr_s = T_ZERO;
          col_s = COL_ZERO;
          if (plane_r != PL_LAST) begin
            plane_s = plane_r + PL_ONE;
            state_s = SHIFT;
          end else if (row_r != ROW_LAST) begin
            plane_s = PL_ZERO;
            row_s   = row_r + ROW_ONE;
            state_s = SHIFT;
          end else begin
            plane_s = PL_ZERO;
            row_s   = ROW_ZERO;
            // Only place besides IDLE where en is looked at.
            if (en) begin
              state_s = SHIFT;
              fs_s    = 1'b1;
            end else begin
              state_s = IDLE;
            end
          end
        end else begin
          tmr_s = tmr_r - T_ONE;
        end
      end
      default: begin
        state_s = IDLE;
        tmr_s   = T_ZERO;
        col_s   = COL_ZERO;
        row_s   = ROW_ZERO;
        plane_s = PL_ZERO;
      end
    endcase
  end

  // State, position and timing counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      tmr_r   <= T_ZERO;
      col_r   <= COL_ZERO;
      row_r   <= ROW_ZERO;
      plane_r <= PL_ZERO;
    end else begin
      state_r <= state_s;
      tmr_r   <= tmr_s;
      col_r   <= col_s;
      row_r   <= row_s;
      plane_r <= plane_s;
    end
  end

  // Panel and fetch outputs registered from the next state so they line up with state_r.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_rd      <= 1'b0;
      clk_out     <= 1'b0;
      latch       <= 1'b0;
      oe          <= 1'b1;
      frame_start <= 1'b0;
      addr        <= ROW_ZERO;
      rgb_r       <= 6'd0;
    end else begin
      pix_rd      <= (state_s == SHIFT) && (tmr_s == T_ZERO);
      clk_out     <= (state_s == SHIFT) && (tmr_s >= T_HIGH);
      latch       <= (state_s == LATCH);
      oe          <= (state_s != DISPLAY);
      frame_start <= fs_s;
      if ((state_s == LATCH) && (plane_s == PL_ZERO)) begin
        addr <= row_s;
      end else begin
        addr <= addr;
      end
      // pix_data is only trusted in the cycle right after the read strobe.
      if ((state_r == SHIFT) && (tmr_r == T_CAP)) begin
        rgb_r <= plane_bits(pix_data, plane_r);
      end else begin
        rgb_r <= rgb_r;
      end
    end
  end

endmodule

// File: tb/tb_hub75_bcm_scan.sv
// Scoreboard bench for hub75_bcm_scan: a frame-level model pushes expected
// reads, colours, latches, dead time and display lengths; a monitor checks them.
`timescale 1ns/1ps
module tb_hub75_bcm_scan;
  localparam int COLS = 4, SCAN_ROWS = 2, ADDR_W = 1, BPC = 2;
  localparam int CLK_DIV = 1, BASE_ON = 4, DEAD_CYC = 3;
`ifdef HUB75_DEADTIME_EN
  localparam int EXP_GAP = DEAD_CYC;
`else
  localparam int EXP_GAP = 0;
`endif

  logic clk = 1'b0;
  logic rst, en, pix_rd, r0, g0, b0, r1, g1, b1, clk_out, latch, oe, frame_start;
  logic [ADDR_W-1:0] pix_row, addr;
  logic [1:0] pix_col;
  logic [6*BPC-1:0] pix_data;

  hub75_bcm_scan #(.COLS(COLS), .SCAN_ROWS(SCAN_ROWS), .ADDR_W(ADDR_W), .BPC(BPC),
                   .CLK_DIV(CLK_DIV), .BASE_ON(BASE_ON), .DEAD_CYC(DEAD_CYC)) dut (
    .clk(clk), .rst(rst), .en(en), .pix_rd(pix_rd), .pix_row(pix_row), .pix_col(pix_col),
    .pix_data(pix_data), .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1),
    .addr(addr), .clk_out(clk_out), .latch(latch), .oe(oe), .frame_start(frame_start));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0, fs_cnt = 0, exp_fs = 0;
  bit mon_en = 0, flush = 0;
  int rd_q[$], rgb_q[$], addr_q[$], gap_q[$], disp_q[$];
  logic [6*BPC-1:0] mem [SCAN_ROWS][COLS];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event missing or unexpected (t=%0t)", name, $time);
  endtask

  // Bit [p] of each colour field, packed as {b1,g1,r1,b0,g0,r0}.
  function automatic int exp_rgb(input logic [6*BPC-1:0] pix, input int p);
    int v, res;
    v = int'(pix);
    res = 0;
    for (int k = 0; k < 6; k++) res |= ((v >> (k*BPC + p)) & 1) << k;
    return res;
  endfunction

  task automatic fill_mem(input bit force_r0);
    for (int r = 0; r < SCAN_ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        mem[r][c] = (6*BPC)'($urandom);
        if (force_r0) mem[r][c][1:0] = 2'b10;
      end
  endtask

  task automatic push_frame();
    for (int r = 0; r < SCAN_ROWS; r++)
      for (int p = 0; p < BPC; p++) begin
        for (int c = 0; c < COLS; c++) begin
          rd_q.push_back(r*COLS + c);
          rgb_q.push_back(exp_rgb(mem[r][c], p));
        end
        addr_q.push_back(r);
        gap_q.push_back(EXP_GAP);
        disp_q.push_back(BASE_ON * (1 << p));
      end
  endtask

  // Pixel source: valid data only in the cycle after pix_rd, junk otherwise.
  initial begin
    bit pend;
    int pr, pc;
    pend = 0; pr = 0; pc = 0;
    pix_data = '0;
    forever begin
      @(negedge clk);
      if (pend) pix_data = mem[pr][pc];
      else pix_data = (6*BPC)'($urandom);
      pend = (pix_rd === 1'b1);
      pr = int'(pix_row);
      pc = int'(pix_col);
    end
  end

  // Monitor: pops expectations as the panel interface produces events.
  initial begin
    logic [5:0] rgb_now;
    logic prev_clk, prev_latch;
    logic [ADDR_W-1:0] prev_addr;
    int run, gap;
    bit gapping;
    run = 0; gap = 0; gapping = 0;
    prev_clk = 0; prev_latch = 0; prev_addr = '0;
    wait (mon_en);
    forever begin
      @(negedge clk);
      rgb_now = {b1, g1, r1, b0, g0, r0};
      if (flush) begin
        run = 0; gapping = 0; flush = 0;
      end else begin
        if (frame_start) fs_cnt++;
        if (pix_rd) begin
          if (rd_q.size() == 0) fail("unexpected_pix_rd");
          else chk("pix_rd_row_col", int'(pix_row)*COLS + int'(pix_col), rd_q.pop_front());
        end
        if (clk_out && !prev_clk) begin
          chk("oe_high_in_shift", int'(oe), 1);
          if (rgb_q.size() == 0) fail("unexpected_clk_out");
          else chk("rgb_at_clk_rise", int'(rgb_now), rgb_q.pop_front());
        end
        if (addr != prev_addr) chk("addr_change_in_latch", int'(latch && oe), 1);
        if (latch) begin
          chk("latch_one_cycle", int'(prev_latch), 0);
          chk("oe_at_latch", int'(oe), 1);
          chk("clk_out_at_latch", int'(clk_out), 0);
          if (addr_q.size() == 0) fail("unexpected_latch");
          else chk("addr_at_latch", int'(addr), addr_q.pop_front());
          gapping = 1; gap = 0;
        end else if (gapping) begin
          if (oe) gap++;
          else begin
            gapping = 0;
            if (gap_q.size() == 0) fail("unexpected_gap");
            else chk("dead_time_gap", gap, gap_q.pop_front());
          end
        end
        if (!oe) run++;
        else if (run > 0) begin
          if (disp_q.size() == 0) fail("unexpected_display");
          else chk("oe_low_length", run, disp_q.pop_front());
          run = 0;
        end
      end
      prev_clk = clk_out; prev_latch = latch; prev_addr = addr;
    end
  end

  task automatic wait_fs(input int target);
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (fs_cnt >= target) return;
    end
    fail("timeout_frame_start");
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(posedge clk); #1;
      if (rd_q.size() == 0 && disp_q.size() == 0 && oe === 1'b1) done = 1;
    end
    if (!done) fail("timeout_frame_end");
    repeat (12) @(posedge clk);
    #1;
    chk("left_rd", rd_q.size(), 0);
    chk("left_rgb", rgb_q.size(), 0);
    chk("left_latch", addr_q.size(), 0);
    chk("left_gap", gap_q.size(), 0);
    chk("left_display", disp_q.size(), 0);
    chk("idle_oe", int'(oe), 1);
    chk("frame_start_count", fs_cnt, exp_fs);
  endtask

  task automatic run_frames(input int nframes, input int drop_after);
    for (int f = 0; f < nframes; f++) push_frame();
    exp_fs += nframes;
    en = 1'b1;
    wait_fs(exp_fs);
    repeat (drop_after) @(posedge clk);
    #1;
    en = 1'b0;
    drain();
  endtask

  initial begin
    bit hit;
    rst = 1'b1; en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_oe", int'(oe), 1);
    chk("rst_latch", int'(latch), 0);
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_pix_rd", int'(pix_rd), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_addr", int'(addr), 0);
    chk("rst_rgb", int'({b1, g1, r1, b0, g0, r0}), 0);
    rst = 1'b0;
    flush = 1; mon_en = 1;
    repeat (5) @(posedge clk);
    #1;

    // r0 field 2'b10 everywhere, en dropped during row 0.
    fill_mem(1'b1);
    run_frames(1, 10);
    // Two frames back to back through the row wrap.
    fill_mem(1'b0);
    run_frames(2, 1);
    // Random frames, random en drop time within row 0.
    for (int i = 0; i < 3; i++) begin
      fill_mem(1'b0);
      run_frames(1, $urandom_range(1, 40));
    end

    // Reset while displaying row 1.
    fill_mem(1'b0);
    push_frame();
    exp_fs++;
    en = 1'b1;
    wait_fs(exp_fs);
    en = 1'b0;
    hit = 0;
    for (int i = 0; i < 500 && !hit; i++) begin
      @(posedge clk); #1;
      if (addr === 1'b1 && oe === 1'b0) hit = 1;
    end
    if (!hit) fail("timeout_row1_display");
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_oe", int'(oe), 1);
    chk("mid_rst_addr", int'(addr), 0);
    chk("mid_rst_latch", int'(latch), 0);
    chk("mid_rst_clk_out", int'(clk_out), 0);
    chk("mid_rst_pix_rd", int'(pix_rd), 0);
    rst = 1'b0;
    rd_q.delete(); rgb_q.delete(); addr_q.delete(); gap_q.delete(); disp_q.delete();
    flush = 1;
    repeat (15) @(posedge clk);
    #1;
    chk("idle_after_rst_oe", int'(oe), 1);
    fill_mem(1'b0);
    run_frames(1, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
